// File: rtl/udma_spis_core.sv
// udma_spis_core: SPI/QPI target engine, fully oversampled in clk_i, with valid/ready word streams.
// Define UDMA_SPIS_RX_SKID_EN to turn the single-entry rx buffer into a 2-entry in-order FIFO.
module udma_spis_core #(
    parameter int SYNC_STAGES = 2,
    parameter int WORD_BITS   = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cfg_en_i,
    input  logic                 cfg_cpol_i,
    input  logic                 cfg_cpha_i,
    input  logic                 cfg_qpi_i,
    input  logic                 cfg_qpi_tx_i,
    output logic [WORD_BITS-1:0] rx_data_o,
    output logic                 rx_valid_o,
    input  logic                 rx_ready_i,
    input  logic [WORD_BITS-1:0] tx_data_i,
    input  logic                 tx_valid_i,
    output logic                 tx_ready_o,
    output logic                 rx_overflow_o,
    output logic                 tx_underflow_o,
    output logic                 eot_o,
    input  logic                 spi_sck_i,
    input  logic                 spi_csn_i,
    input  logic                 spi_sdi0_i,
    input  logic                 spi_sdi1_i,
    input  logic                 spi_sdi2_i,
    input  logic                 spi_sdi3_i,
    output logic                 spi_sdo0_o,
    output logic                 spi_sdo1_o,
    output logic                 spi_sdo2_o,
    output logic                 spi_sdo3_o,
    output logic [3:0]           spi_oe_o
);
    localparam int CW = $clog2(WORD_BITS + 1);
    localparam logic [CW-1:0] WORD_CNT = CW'(WORD_BITS);
    localparam logic [CW-1:0] STEP_SPI = CW'(1);
    localparam logic [CW-1:0] STEP_QPI = CW'(4);

    typedef enum logic {IDLE, ACTIVE} state_t;

    // Bus inputs packed as {csn, sck, sdi3..sdi0}; resetting to 0 means a CSN held
    // low across reset release never looks like a falling edge.
    logic [SYNC_STAGES-1:0][5:0] sync_reg;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) sync_reg <= '0;
        else sync_reg <= {sync_reg[SYNC_STAGES-2:0],
                          {spi_csn_i, spi_sck_i, spi_sdi3_i, spi_sdi2_i, spi_sdi1_i, spi_sdi0_i}};
    end

    logic [5:0] sync_s;
    logic       csn_s, sck_s;
    logic [3:0] sdi_s;
    assign sync_s = sync_reg[SYNC_STAGES-1];
    assign csn_s  = sync_s[5];
    assign sck_s  = sync_s[4];
    assign sdi_s  = sync_s[3:0];

    state_t               state_reg;
    logic                 csn_prev_reg, sck_prev_reg, frame_open_reg, eot_reg;
    logic                 samp_rise_reg, qpi_reg, qpi_tx_reg;
    logic [3:0]           oe_reg;
    logic [WORD_BITS-1:0] tx_shift_reg, rx_shift_reg;
    logic [CW-1:0]        tx_left_reg, rx_cnt_reg;

    logic csn_fall, csn_rise, sck_rise, sck_fall, start, stop, run;
    logic sample_edge, shift_edge, tx_en, rx_en, tx_load, rx_done;
    logic [CW-1:0]        step, start_step, rx_cnt_next;
    logic [WORD_BITS-1:0] tx_word, rx_next;

    assign csn_fall    = ~csn_s & csn_prev_reg;
    assign csn_rise    = csn_s & ~csn_prev_reg;
    assign sck_rise    = sck_s & ~sck_prev_reg;
    assign sck_fall    = ~sck_s & sck_prev_reg;
    assign start       = (state_reg == IDLE) & csn_fall & cfg_en_i;
    assign stop        = (state_reg == ACTIVE) & (csn_rise | ~cfg_en_i);
    assign run         = (state_reg == ACTIVE) & ~stop;
    assign sample_edge = run & (samp_rise_reg ? sck_rise : sck_fall);
    assign shift_edge  = run & (samp_rise_reg ? sck_fall : sck_rise);
    assign tx_en       = ~qpi_reg | qpi_tx_reg;
    assign rx_en       = ~(qpi_reg & qpi_tx_reg);
    assign step        = qpi_reg ? STEP_QPI : STEP_SPI;
    assign start_step  = cfg_qpi_i ? STEP_QPI : STEP_SPI;

    // tx_left counts bits still to present after the current one; reaching 0 at a
    // shift edge means the next word is due (covers both CPHA variants).
    assign tx_load = (start & ~cfg_cpha_i & (~cfg_qpi_i | cfg_qpi_tx_i))
                   | (shift_edge & tx_en & (tx_left_reg == '0));
    assign tx_word        = tx_valid_i ? tx_data_i : '0;
    assign tx_ready_o     = tx_load & tx_valid_i;
    assign tx_underflow_o = tx_load & ~tx_valid_i;

    assign rx_next     = qpi_reg ? {rx_shift_reg[WORD_BITS-5:0], sdi_s}
                                 : {rx_shift_reg[WORD_BITS-2:0], sdi_s[0]};
    assign rx_cnt_next = rx_cnt_reg + step;
    assign rx_done     = sample_edge & rx_en & (rx_cnt_next == WORD_CNT);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg      <= IDLE;
            csn_prev_reg   <= 1'b0;
            sck_prev_reg   <= 1'b0;
            frame_open_reg <= 1'b0;
            eot_reg        <= 1'b0;
            samp_rise_reg  <= 1'b0;
            qpi_reg        <= 1'b0;
            qpi_tx_reg     <= 1'b0;
            oe_reg         <= '0;
            tx_shift_reg   <= '0;
            rx_shift_reg   <= '0;
            tx_left_reg    <= '0;
            rx_cnt_reg     <= '0;
        end else begin
            csn_prev_reg <= csn_s;
            sck_prev_reg <= sck_s;
            // eot follows the frame, not the state, so a cfg_en_i drop still ends with eot at CSN rise.
            eot_reg      <= csn_rise & frame_open_reg;
            if (start) frame_open_reg <= 1'b1;
            else if (csn_rise) frame_open_reg <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg     <= ACTIVE;
                        samp_rise_reg <= (cfg_cpol_i == cfg_cpha_i);
                        qpi_reg       <= cfg_qpi_i;
                        qpi_tx_reg    <= cfg_qpi_tx_i;
                        oe_reg        <= cfg_qpi_i ? (cfg_qpi_tx_i ? 4'hF : 4'h0) : 4'b0010;
                        rx_cnt_reg    <= '0;
                        rx_shift_reg  <= '0;
                        tx_shift_reg  <= tx_load ? tx_word : '0;
                        tx_left_reg   <= tx_load ? WORD_CNT - start_step : '0;
                    end
                end
                ACTIVE: begin
                    if (stop) begin
                        state_reg    <= IDLE;
                        oe_reg       <= '0;
                        tx_shift_reg <= '0;
                        tx_left_reg  <= '0;
                        rx_cnt_reg   <= '0;
                        rx_shift_reg <= '0;
                    end else begin
                        if (sample_edge & rx_en) begin
                            rx_shift_reg <= rx_next;
                            rx_cnt_reg   <= rx_done ? '0 : rx_cnt_next;
                        end
                        if (tx_load) begin
                            tx_shift_reg <= tx_word;
                            tx_left_reg  <= WORD_CNT - step;
                        end else if (shift_edge & tx_en) begin
                            tx_shift_reg <= qpi_reg ? tx_shift_reg << 4 : tx_shift_reg << 1;
                            tx_left_reg  <= tx_left_reg - step;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign eot_o      = eot_reg;
    assign spi_oe_o   = oe_reg;
    assign spi_sdo3_o = qpi_reg & tx_shift_reg[WORD_BITS-1];
    assign spi_sdo2_o = qpi_reg & tx_shift_reg[WORD_BITS-2];
    assign spi_sdo1_o = qpi_reg ? tx_shift_reg[WORD_BITS-3] : tx_shift_reg[WORD_BITS-1];
    assign spi_sdo0_o = qpi_reg & tx_shift_reg[WORD_BITS-4];

    logic rx_pop;
    logic ovf_reg;
    assign rx_pop        = rx_valid_o & rx_ready_i;
    assign rx_overflow_o = ovf_reg;

`ifdef UDMA_SPIS_RX_SKID_EN
    logic [WORD_BITS-1:0] rx_head_reg, rx_tail_reg;
    logic [1:0]           rx_fill_reg;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_head_reg <= '0;
            rx_tail_reg <= '0;
            rx_fill_reg <= '0;
            ovf_reg     <= 1'b0;
        end else begin
            ovf_reg <= rx_done & (rx_fill_reg == 2'd2) & ~rx_pop;
            if (rx_pop) begin
                if (rx_done && rx_fill_reg == 2'd1) begin
                    rx_head_reg <= rx_next;
                end else if (rx_done) begin
                    rx_head_reg <= rx_tail_reg;
                    rx_tail_reg <= rx_next;
                end else begin
                    rx_head_reg <= rx_tail_reg;
                    rx_fill_reg <= rx_fill_reg - 2'd1;
                end
            end else if (rx_done && rx_fill_reg != 2'd2) begin
                if (rx_fill_reg == 2'd0) rx_head_reg <= rx_next;
                else rx_tail_reg <= rx_next;
                rx_fill_reg <= rx_fill_reg + 2'd1;
            end
        end
    end

    assign rx_data_o  = rx_head_reg;
    assign rx_valid_o = (rx_fill_reg != 2'd0);
`else
    logic [WORD_BITS-1:0] rx_buf_reg;
    logic                 rx_valid_reg;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_buf_reg   <= '0;
            rx_valid_reg <= 1'b0;
            ovf_reg      <= 1'b0;
        end else begin
            ovf_reg <= rx_done & rx_valid_reg & ~rx_ready_i;
            if (rx_done && (!rx_valid_reg || rx_ready_i)) begin
                rx_buf_reg   <= rx_next;
                rx_valid_reg <= 1'b1;
            end else if (rx_pop) begin
                rx_valid_reg <= 1'b0;
            end
        end
    end

    assign rx_data_o  = rx_buf_reg;
    assign rx_valid_o = rx_valid_reg;
`endif
endmodule

// File: tb/tb_udma_spis_core.sv
// Directed bench for udma_spis_core: a behavioural SPI/QPI master drives the bus and checks each result.
`timescale 1ns/1ps
module tb_udma_spis_core;
    localparam int HALF = 8;

    logic        clk = 1'b0, rst = 1'b1;
    logic        cfg_en = 1'b1, cfg_cpol = 1'b0, cfg_cpha = 1'b0, cfg_qpi = 1'b0, cfg_qpi_tx = 1'b0;
    logic [31:0] rx_data;
    logic        rx_valid, rx_ready = 1'b0;
    logic [31:0] tx_data = '0;
    logic        tx_valid = 1'b0, tx_ready, rx_overflow, tx_underflow, eot;
    logic        sck = 1'b0, csn = 1'b1, sdi0 = 1'b0, sdi1 = 1'b0, sdi2 = 1'b0, sdi3 = 1'b0;
    logic        sdo0, sdo1, sdo2, sdo3;
    logic [3:0]  oe;

    always #5 clk = ~clk;

    udma_spis_core dut (
        .clk_i(clk), .rst_i(rst), .cfg_en_i(cfg_en), .cfg_cpol_i(cfg_cpol), .cfg_cpha_i(cfg_cpha),
        .cfg_qpi_i(cfg_qpi), .cfg_qpi_tx_i(cfg_qpi_tx), .rx_data_o(rx_data), .rx_valid_o(rx_valid),
        .rx_ready_i(rx_ready), .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready),
        .rx_overflow_o(rx_overflow), .tx_underflow_o(tx_underflow), .eot_o(eot),
        .spi_sck_i(sck), .spi_csn_i(csn), .spi_sdi0_i(sdi0), .spi_sdi1_i(sdi1), .spi_sdi2_i(sdi2),
        .spi_sdi3_i(sdi3), .spi_sdo0_o(sdo0), .spi_sdo1_o(sdo1), .spi_sdo2_o(sdo2),
        .spi_sdo3_o(sdo3), .spi_oe_o(oe)
    );

    logic [44:0] all_out;
    assign all_out = {rx_data, rx_valid, tx_ready, rx_overflow, tx_underflow, eot,
                      sdo3, sdo2, sdo1, sdo0, oe};

    int n_checks = 0, n_errors = 0;
    int n_txr = 0, n_unf = 0, n_ovf = 0, n_eot = 0, rx_n = 0;
    logic [31:0] rx_log [64];
    logic [63:0] miso;

    // Pulse and handshake monitor; tests compare deltas of these totals.
    always @(negedge clk) begin
        if (tx_ready) n_txr++;
        if (tx_underflow) n_unf++;
        if (rx_overflow) n_ovf++;
        if (eot) n_eot++;
        if (rx_valid && rx_ready && rx_n < 64) begin
            rx_log[rx_n] = rx_data;
            rx_n++;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] d);
        if (cfg_qpi) {sdi3, sdi2, sdi1, sdi0} = d[31:28];
        else sdi0 = d[31];
    endtask

    task automatic grab();
        if (cfg_qpi) miso = {miso[59:0], sdo3, sdo2, sdo1, sdo0};
        else miso = {miso[62:0], sdo1};
    endtask

    // One SCK cycle per bit (SPI) or nibble (QPI), MSB first.
    task automatic send_bits(input logic [31:0] w, input int ncyc);
        logic [31:0] d;
        d = w;
        for (int i = 0; i < ncyc; i++) begin
            if (!cfg_cpha) begin
                drive(d);
                wait_cyc(HALF);
                grab();
                sck = ~cfg_cpol;
                wait_cyc(HALF);
                sck = cfg_cpol;
            end else begin
                sck = ~cfg_cpol;
                drive(d);
                wait_cyc(HALF);
                grab();
                sck = cfg_cpol;
                wait_cyc(HALF);
            end
            d = cfg_qpi ? d << 4 : d << 1;
        end
    endtask

    task automatic frame_start();
        sck  = cfg_cpol;
        miso = '0;
        wait_cyc(HALF);
        csn = 1'b0;
        wait_cyc(HALF);
    endtask

    task automatic frame_end();
        wait_cyc(HALF);
        csn = 1'b1;
        wait_cyc(2 * HALF);
    endtask

    task automatic pop();
        rx_ready = 1'b1;
        wait_cyc(1);
        rx_ready = 1'b0;
    endtask

`ifdef UDMA_SPIS_RX_SKID_EN
    localparam int OVF_EXP = 1;
`else
    localparam int OVF_EXP = 2;
`endif

    int b_txr, b_unf, b_ovf, b_eot, b_rx;

    task automatic snap();
        b_txr = n_txr; b_unf = n_unf; b_ovf = n_ovf; b_eot = n_eot; b_rx = rx_n;
    endtask

    initial begin
        // Reset state
        wait_cyc(3);
        check("reset_outputs", 64'(all_out), 64'd0);
        rst = 1'b0;
        wait_cyc(4);

        // Mode 0 SPI, one word each way
        snap();
        cfg_cpol = 0; cfg_cpha = 0; cfg_qpi = 0; cfg_qpi_tx = 0;
        tx_data = 32'hA5C3_0F81; tx_valid = 1'b1; rx_ready = 1'b0;
        frame_start();
        send_bits(32'h1234_5678, 4);
        check("m0_oe", 64'(oe), 64'h2);
        tx_valid = 1'b0;
        send_bits(32'h2345_6780, 28);
        frame_end();
        check("m0_miso", miso[31:0], 64'hA5C3_0F81);
        check("m0_rx_data", 64'(rx_data), 64'h1234_5678);
        check("m0_rx_valid", 64'(rx_valid), 64'd1);
        check("m0_tx_ready_pulses", 64'(n_txr - b_txr), 64'd1);
        check("m0_eot_pulses", 64'(n_eot - b_eot), 64'd1);
        check("m0_oe_idle", 64'(oe), 64'h0);
        pop();
        check("m0_rx_consumed", 64'(rx_valid), 64'd0);

        // Mode 3, two back-to-back words
        snap();
        cfg_cpol = 1; cfg_cpha = 1;
        tx_data = 32'h1357_9BDF; tx_valid = 1'b1; rx_ready = 1'b1;
        frame_start();
        send_bits(32'hDEAD_BEEF, 32);
        tx_data = 32'h2468_ACE0;
        send_bits(32'hCAFE_F00D, 32);
        tx_valid = 1'b0;
        frame_end();
        check("m3_rx_count", 64'(rx_n - b_rx), 64'd2);
        check("m3_rx_word0", 64'(rx_log[b_rx]), 64'hDEAD_BEEF);
        check("m3_rx_word1", 64'(rx_log[b_rx + 1]), 64'hCAFE_F00D);
        check("m3_miso", miso, 64'h1357_9BDF_2468_ACE0);
        check("m3_tx_ready_pulses", 64'(n_txr - b_txr), 64'd2);
        check("m3_underflow", 64'(n_unf - b_unf), 64'd0);
        check("m3_overflow", 64'(n_ovf - b_ovf), 64'd0);

        // QPI receive
        cfg_cpol = 0; cfg_cpha = 0; cfg_qpi = 1; cfg_qpi_tx = 0; rx_ready = 1'b0;
        frame_start();
        send_bits(32'h0123_4567, 4);
        check("qrx_oe", 64'(oe), 64'h0);
        send_bits(32'h4567_0000, 4);
        frame_end();
        check("qrx_rx_data", 64'(rx_data), 64'h0123_4567);
        check("qrx_rx_valid", 64'(rx_valid), 64'd1);
        pop();

        // QPI transmit
        snap();
        cfg_qpi_tx = 1; tx_data = 32'h89AB_CDEF; tx_valid = 1'b1;
        frame_start();
        send_bits(32'h0, 4);
        check("qtx_oe", 64'(oe), 64'hF);
        tx_valid = 1'b0;
        send_bits(32'h0, 4);
        frame_end();
        check("qtx_nibbles", miso[31:0], 64'h89AB_CDEF);
        check("qtx_no_rx", 64'(rx_valid), 64'd0);
        check("qtx_tx_ready_pulses", 64'(n_txr - b_txr), 64'd1);

        // Overflow with rx_ready held low
        snap();
        cfg_qpi = 0; cfg_qpi_tx = 0; rx_ready = 1'b0;
        frame_start();
        send_bits(32'h1111_2222, 32);
        send_bits(32'h3333_4444, 32);
        send_bits(32'h5555_6666, 32);
        frame_end();
        check("ovf_pulses", 64'(n_ovf - b_ovf), 64'(OVF_EXP));
        check("ovf_first_kept", 64'(rx_data), 64'h1111_2222);
        pop();
`ifdef UDMA_SPIS_RX_SKID_EN
        check("ovf_second_valid", 64'(rx_valid), 64'd1);
        check("ovf_second_kept", 64'(rx_data), 64'h3333_4444);
        pop();
`endif
        check("ovf_drained", 64'(rx_valid), 64'd0);

        // Underflow: no tx word at the first load (mode 3 loads once per word)
        snap();
        cfg_cpol = 1; cfg_cpha = 1; tx_data = 32'hFFFF_FFFF; tx_valid = 1'b0; rx_ready = 1'b1;
        frame_start();
        send_bits(32'h0F0F_0F0F, 32);
        frame_end();
        check("unf_pulses", 64'(n_unf - b_unf), 64'd1);
        check("unf_sdo_zero", miso[31:0], 64'd0);
        check("unf_no_tx_ready", 64'(n_txr - b_txr), 64'd0);
        check("unf_rx_word", 64'(rx_log[b_rx]), 64'h0F0F_0F0F);

        // Partial word, then a full frame
        snap();
        cfg_cpol = 0; cfg_cpha = 0;
        frame_start();
        send_bits(32'hAAAA_AAAA, 13);
        frame_end();
        check("part_no_rx", 64'(rx_n - b_rx), 64'd0);
        check("part_no_valid", 64'(rx_valid), 64'd0);
        frame_start();
        send_bits(32'hFFFF_0000, 32);
        frame_end();
        check("part_next_count", 64'(rx_n - b_rx), 64'd1);
        check("part_next_word", 64'(rx_log[b_rx]), 64'hFFFF_0000);
        check("part_eot_pulses", 64'(n_eot - b_eot), 64'd2);

        // Reset mid-frame; CSN still low afterwards must not start a frame
        tx_data = 32'hFFFF_FFFF; tx_valid = 1'b1; rx_ready = 1'b0;
        frame_start();
        send_bits(32'hFFFF_FFFF, 10);
        rst = 1'b1;
        wait_cyc(1);
        check("rst_mid_outputs", 64'(all_out), 64'd0);
        wait_cyc(2);
        rst = 1'b0;
        snap();
        send_bits(32'hFFC0_0000, 22);
        frame_end();
        check("rst_no_eot", 64'(n_eot - b_eot), 64'd0);
        check("rst_no_tx_ready", 64'(n_txr - b_txr), 64'd0);
        check("rst_no_rx", 64'(rx_valid), 64'd0);
        tx_valid = 1'b0; rx_ready = 1'b1;
        frame_start();
        send_bits(32'h3C3C_3C3C, 32);
        frame_end();
        check("rst_fresh_frame", 64'(rx_log[b_rx]), 64'h3C3C_3C3C);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
